ternary_weight_sequencer: RTL and testbench

Upstream stage of the ternary matrix-vector multiplier. Accepts the 16×8 ternary weight matrix as a byte stream, stores it, then drives the multiplier's row counter, enable and per-row weight slice every cycle. Loading and running are exclusive phases. A new load may pre-empt a running frame at any time.

---
 rtl/ternary_weight_sequencer_pkg.sv | 36 +++
 rtl/ternary_weight_store.sv | 32 +++
 rtl/ternary_weight_sequencer.sv | 120 ++++++++++++
 tb/tb_ternary_weight_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ternary_weight_sequencer_pkg.sv
// Shared definitions for the ternary matrix-vector multiplier path:
// sequencer states, weight coding and matrix geometry.
package ternary_weight_sequencer_pkg;

  localparam int IN_LEN  = 16;
  localparam int OUT_LEN = 8;
  localparam int ROWS    = IN_LEN / 2;

  function automatic int weight_bytes(input int in_len, input int out_len);
    return (2 * in_len * out_len) / 8;
  endfunction

  localparam int WEIGHT_BYTES = weight_bytes(IN_LEN, OUT_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b10;

  // Code 11 shares the -1 meaning with 10; only the MSB marks a negative weight.
  function automatic logic signed [1:0] decode_weight(input logic [1:0] code);
    logic signed [1:0] val;
    val = 2'sd0;
    if (code[1])
      val = -2'sd1;
    else if (code == W_POS)
      val = 2'sd1;
    return val;
  endfunction

endpackage

// File: rtl/ternary_weight_store.sv
// Byte-addressed weight matrix register with a per-row slice read mux.
module ternary_weight_store
  import ternary_weight_sequencer_pkg::*;
#(
  parameter int NumBytes = WEIGHT_BYTES,
  parameter int SliceW   = 32,
  parameter int RowW     = 3,
  parameter int AddrW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AddrW-1:0]  wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [RowW-1:0]   rd_row,
  output logic [SliceW-1:0] rd_data
);

  logic [NumBytes*8-1:0] wmem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wmem <= '0;
    else if (wr_en)
      wmem[{wr_addr, 3'b000} +: 8] <= wr_data;
  end

  // Gated to zero outside RUN so the multiplier never sees a half-loaded matrix.
  assign rd_data = rd_en ? wmem[rd_row * SliceW +: SliceW] : '0;

endmodule

// File: rtl/ternary_weight_sequencer.sv
// Loads a ternary weight matrix from a byte stream and then streams it
// row by row to the multiplier; a new load may pre-empt a running frame.
//
//   state | meaning
//   IDLE  | no matrix held, waiting for the first byte
//   LOAD  | collecting bytes 1..N-1 at bcnt, pauses allowed
//   RUN   | matrix complete, row sweeps 0..ROWS-1 every cycle
module ternary_weight_sequencer
  import ternary_weight_sequencer_pkg::*;
#(
  parameter int InLen    = 16,
  parameter int OutLen   = 8,
  parameter int BitWidth = 8,
  localparam int Rows    = InLen / 2,
  localparam int RowW    = $clog2(Rows),
  localparam int NBytes  = weight_bytes(InLen, OutLen),
  localparam int AddrW   = $clog2(NBytes),
  localparam int SliceW  = 4 * OutLen
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [7:0]        load_data,
  output logic [RowW-1:0]   row,
  output logic              en,
  output logic [SliceW-1:0] w_row,
  output logic              loaded,
  output logic              frame_done
);

  if (BitWidth < 1 || (InLen % 2) != 0) begin : g_param_check
    $error("ternary_weight_sequencer: InLen must be even and BitWidth positive");
  end

  localparam logic [AddrW-1:0] LastByte = AddrW'(NBytes - 1);
  localparam logic [RowW-1:0]  LastRow  = RowW'(Rows - 1);

  seq_state_e       state_q, state_d;
  logic [AddrW-1:0] bcnt_q, bcnt_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [AddrW-1:0] wr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    row_d   = row_q;
    wr_addr = '0;
    case (state_q)
      IDLE: begin
        row_d = '0;
        if (load_en) begin
          bcnt_d  = AddrW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        row_d   = '0;
        wr_addr = bcnt_q;
        if (load_en) begin
          if (bcnt_q == LastByte) begin
            bcnt_d  = '0;
            state_d = RUN;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        row_d = (row_q == LastRow) ? '0 : row_q + 1'b1;
        // Abort: the incoming byte becomes byte 0 of the replacement matrix.
        if (load_en) begin
          bcnt_d  = AddrW'(1);
          row_d   = '0;
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        bcnt_d  = '0;
        row_d   = '0;
      end
    endcase
  end

  ternary_weight_store #(
    .NumBytes (NBytes),
    .SliceW   (SliceW),
    .RowW     (RowW),
    .AddrW    (AddrW)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (load_en),
    .wr_addr (wr_addr),
    .wr_data (load_data),
    .rd_en   (en),
    .rd_row  (row_q),
    .rd_data (w_row)
  );

  // Completing a load always enters RUN and leaving RUN always starts a new
  // load, so "complete matrix held" coincides with the RUN state.
  assign en         = (state_q == RUN);
  assign loaded     = en;
  assign row        = row_q;
  assign frame_done = en && (row_q == LastRow);

endmodule

// File: tb/tb_ternary_weight_sequencer.sv
// Directed self-checking bench for ternary_weight_sequencer.
module tb_ternary_weight_sequencer;
  import ternary_weight_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [7:0]  load_data;
  logic [2:0]  row;
  logic        en;
  logic [31:0] w_row;
  logic        loaded;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  ternary_weight_sequencer #(
    .InLen    (16),
    .OutLen   (8),
    .BitWidth (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_data  (load_data),
    .row        (row),
    .en         (en),
    .w_row      (w_row),
    .loaded     (loaded),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp_v);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    load_en   = 1'b1;
    load_data = b;
    @(posedge clk);
    #1;
    load_en   = 1'b0;
    load_data = 8'h00;
  endtask

  task automatic send_ramp(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) send(start + 8'(i));
  endtask

  task automatic send_const(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  logic en_seen;
  logic wr_seen;

  initial begin
    rst_n     = 1'b0;
    load_en   = 1'b0;
    load_data = 8'h00;
    #12 rst_n = 1'b1;
    step(1);
    chk("rst_en", en, 0);
    chk("rst_row", row, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_wrow", w_row, 0);

    // full back-to-back load
    send_ramp(8'h00, 32);
    chk("full_en", en, 1);
    chk("full_loaded", loaded, 1);
    chk("full_row0", row, 0);
    chk("full_wrow0", w_row, 32'h03020100);
    chk("full_fd0", frame_done, 0);
    step(4);
    chk("full_row4", row, 4);
    chk("full_wrow4", w_row, 32'h13121110);
    step(3);
    chk("full_row7", row, 7);
    chk("full_wrow7", w_row, 32'h1F1E1D1C);
    chk("full_fd7", frame_done, 1);
    step(1);
    chk("full_wrap_row", row, 0);
    chk("full_wrap_fd", frame_done, 0);
    step(7);
    chk("full_fd_again", frame_done, 1);

    // asynchronous reset mid-run
    #3 rst_n = 1'b0;
    #1;
    chk("arst_en", en, 0);
    chk("arst_row", row, 0);
    chk("arst_wrow", w_row, 0);
    chk("arst_loaded", loaded, 0);
    chk("arst_fd", frame_done, 0);
    chk("arst_wmem", dut.u_store.wmem, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_en", en, 0);
    end
    chk("idle_state", 256'(dut.state_q), 256'(IDLE));

    // paused load
    send_ramp(8'h00, 10);
    chk("pause_en", en, 0);
    chk("pause_bcnt", dut.bcnt_q, 10);
    en_seen = 1'b0;
    wr_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      en_seen |= en;
      wr_seen |= |w_row;
    end
    chk("pause_en_held", en_seen, 0);
    chk("pause_wrow_zero", wr_seen, 0);
    send_ramp(8'h0A, 22);
    chk("pause_done_en", en, 1);
    chk("pause_wrow0", w_row, 32'h03020100);
    step(7);
    chk("pause_wrow7", w_row, 32'h1F1E1D1C);

    // abort during run at row 4
    step(5);
    chk("abort_pre_row", row, 4);
    chk("abort_pre_en", en, 1);
    send(8'hAA);
    chk("abort_en", en, 0);
    chk("abort_loaded", loaded, 0);
    chk("abort_state", 256'(dut.state_q), 256'(LOAD));
    chk("abort_bcnt", dut.bcnt_q, 1);
    chk("abort_byte0", dut.u_store.wmem[7:0], 8'hAA);
    chk("abort_row", row, 0);
    send_ramp(8'h81, 31);
    chk("abort_run_en", en, 1);
    chk("abort_run_row", row, 0);
    chk("abort_wrow0", w_row, 32'h838281AA);
    step(7);
    chk("abort_wrow7", w_row, 32'h9F9E9D9C);

    // reset mid-load, then a fresh load of 0x55
    send_const(8'h11, 16);
    chk("midload_bcnt", dut.bcnt_q, 16);
    #3 rst_n = 1'b0;
    #1;
    chk("midload_wmem", dut.u_store.wmem, 0);
    chk("midload_state", 256'(dut.state_q), 256'(IDLE));
    chk("midload_bcnt0", dut.bcnt_q, 0);
    #3 rst_n = 1'b1;
    step(1);
    send_const(8'h55, 32);
    for (int r = 0; r < 8; r++) begin
      chk("p55_row", row, r);
      chk("p55_wrow", w_row, 32'h55555555);
      step(1);
    end

    // code 11 stored unmodified
    send_const(8'hFF, 32);
    chk("pff_en", en, 1);
    chk("pff_wrow0", w_row, 32'hFFFFFFFF);
    step(3);
    chk("pff_wrow3", w_row, 32'hFFFFFFFF);
    chk("pff_wmem", dut.u_store.wmem, {256{1'b1}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
